apb_rr_arbiter: RTL and testbench

APB_RR_ARBITER -- requirements
Module: apb_rr_arbiter

---
 rtl/apb_rr_arbiter_pkg.sv | 19 +
 rtl/apb_rr_arbiter_if.sv | 36 +++
 rtl/apb_rr_arbiter_pick.sv | 32 +++
 rtl/apb_rr_arbiter.sv | 110 +++++++++++
 tb/tb_apb_rr_arbiter.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/apb_rr_arbiter_pkg.sv
// Shared SoC APB configuration: bus widths, arbiter state encoding and timeout defaults.
package apb_rr_arbiter_pkg;

    localparam int unsigned APB_WIDTH      = 20;
    localparam int unsigned APB_DATA_WIDTH = 16;
    localparam logic [15:0] TIMEOUT_DATA_DEF = 16'hDEAD;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    // Index width that stays legal for a single port.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_rr_arbiter_if.sv
// Core-side APB request lanes plus the shared decoder-side APB bus.
interface apb_rr_arbiter_if
    import apb_rr_arbiter_pkg::*;
#(
    parameter int unsigned MASTER_PORTS = 4,
    parameter int unsigned BUS_WIDTH    = APB_WIDTH,
    parameter int unsigned DATA_WIDTH   = APB_DATA_WIDTH
);
    logic [MASTER_PORTS*BUS_WIDTH-1:0]  S_PADDR;
    logic [MASTER_PORTS-1:0]            S_PWRITE;
    logic [MASTER_PORTS-1:0]            S_PSELx;
    logic [MASTER_PORTS-1:0]            S_PENABLE;
    logic [MASTER_PORTS*DATA_WIDTH-1:0] S_PWDATA;
    logic [MASTER_PORTS*DATA_WIDTH-1:0] S_PRDATA;
    logic [MASTER_PORTS-1:0]            S_PREADY;

    logic [BUS_WIDTH-1:0]               M_PADDR;
    logic                               M_PWRITE;
    logic                               M_PSEL;
    logic                               M_PENABLE;
    logic [DATA_WIDTH-1:0]              M_PWDATA;
    logic [DATA_WIDTH-1:0]              M_PRDATA;
    logic                               M_PREADY;

    // Arbiter view: slave to the cores, master toward the decoder.
    modport slave (
        input  S_PADDR, S_PWRITE, S_PSELx, S_PENABLE, S_PWDATA, M_PRDATA, M_PREADY,
        output S_PRDATA, S_PREADY, M_PADDR, M_PWRITE, M_PSEL, M_PENABLE, M_PWDATA
    );

    // Environment view: the cores and the decoded slave.
    modport master (
        output S_PADDR, S_PWRITE, S_PSELx, S_PENABLE, S_PWDATA, M_PRDATA, M_PREADY,
        input  S_PRDATA, S_PREADY, M_PADDR, M_PWRITE, M_PSEL, M_PENABLE, M_PWDATA
    );
endinterface

// File: rtl/apb_rr_arbiter_pick.sv
// Round-robin picker: first requester above last_grant, wrapping, as one-hot and index.
module apb_rr_pick
    import apb_rr_arbiter_pkg::*;
#(
    parameter int unsigned MASTER_PORTS = 4
)(
    input  logic [MASTER_PORTS-1:0]                req,
    input  logic [idx_width(MASTER_PORTS)-1:0]     last,
    output logic [MASTER_PORTS-1:0]                onehot,
    output logic [idx_width(MASTER_PORTS)-1:0]     idx
);
    localparam int unsigned IDX_W = idx_width(MASTER_PORTS);

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        cand   = '0;
        for (int k = 1; k <= int'(MASTER_PORTS); k++) begin
            cand = IDX_W'((32'(last) + 32'(k)) % MASTER_PORTS);
            if (!found && req[cand]) begin
                found        = 1'b1;
                idx          = cand;
                onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_rr_arbiter.sv
// Round-robin APB arbiter: N core masters share one APB bus, with wait-state timeout.
module apb_rr_arbiter
    import apb_rr_arbiter_pkg::*;
#(
    parameter int unsigned           MASTER_PORTS = 4,
    parameter int unsigned           BUS_WIDTH    = APB_WIDTH,
    parameter int unsigned           DATA_WIDTH   = APB_DATA_WIDTH,
    parameter int unsigned           TIMEOUT      = 255,
    parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA = DATA_WIDTH'(TIMEOUT_DATA_DEF)
)(
    input  logic                    clk,
    input  logic                    reset,
    apb_rr_arbiter_if.slave         bus,
    output logic [MASTER_PORTS-1:0] grant,
    output logic                    timeout_err
);
    localparam int unsigned IDX_W     = idx_width(MASTER_PORTS);
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    apb_state_e                state;
    logic [IDX_W-1:0]          gidx;
    logic [IDX_W-1:0]          last_grant;
    logic [15:0]               wait_cnt;
    logic [MASTER_PORTS-1:0]   pick_onehot;
    logic [IDX_W-1:0]          pick_idx;
    logic                      sel_g;
    logic                      rdy;
    logic                      tmo;
    logic [DATA_WIDTH-1:0]     rsp_data;

    apb_rr_pick #(.MASTER_PORTS(MASTER_PORTS)) u_pick (
        .req    (bus.S_PSELx),
        .last   (last_grant),
        .onehot (pick_onehot),
        .idx    (pick_idx)
    );

    // Completion qualifiers; a dropped PSEL (abort) suppresses both.
    always_comb begin
        sel_g    = |(bus.S_PSELx & grant);
        rdy      = (state == ST_ACCESS) && sel_g && bus.M_PREADY;
        tmo      = (state == ST_ACCESS) && sel_g && !bus.M_PREADY && (wait_cnt == WAIT_LAST);
        rsp_data = rdy ? bus.M_PRDATA : (tmo ? TIMEOUT_DATA : '0);
    end

    assign timeout_err   = tmo;
    assign bus.M_PSEL    = (state != ST_IDLE);
    assign bus.M_PENABLE = (state == ST_ACCESS);
    assign bus.S_PREADY  = (rdy || tmo) ? grant : '0;

    // Grant is zero in IDLE, so the OR-mux yields zeros there.
    always_comb begin
        bus.M_PADDR  = '0;
        bus.M_PWRITE = 1'b0;
        bus.M_PWDATA = '0;
        bus.S_PRDATA = '0;
        for (int i = 0; i < int'(MASTER_PORTS); i++) begin
            if (grant[i]) begin
                bus.M_PADDR  = bus.M_PADDR  | bus.S_PADDR[i*BUS_WIDTH +: BUS_WIDTH];
                bus.M_PWRITE = bus.M_PWRITE | bus.S_PWRITE[i];
                bus.M_PWDATA = bus.M_PWDATA | bus.S_PWDATA[i*DATA_WIDTH +: DATA_WIDTH];
                bus.S_PRDATA[i*DATA_WIDTH +: DATA_WIDTH] = rsp_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            grant      <= '0;
            gidx       <= '0;
            last_grant <= IDX_W'(MASTER_PORTS - 1);
            wait_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|bus.S_PSELx) begin
                        grant <= pick_onehot;
                        gidx  <= pick_idx;
                        state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (!sel_g) begin
                        state      <= ST_IDLE;
                        grant      <= '0;
                        last_grant <= gidx;
                    end else begin
                        state    <= ST_ACCESS;
                        wait_cnt <= '0;
                    end
                end
                ST_ACCESS: begin
                    if (!sel_g || rdy || tmo) begin
                        state      <= ST_IDLE;
                        grant      <= '0;
                        last_grant <= gidx;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Directed bench for apb_rr_arbiter: 4 masters, TIMEOUT=8.
module tb_apb_rr_arbiter;

    localparam int unsigned MP = 4;
    localparam int unsigned BW = 20;
    localparam int unsigned DW = 16;

    logic          clk;
    logic          reset;
    logic [MP-1:0] grant;
    logic          timeout_err;

    int n_checks = 0;
    int n_errors = 0;

    apb_rr_arbiter_if #(.MASTER_PORTS(MP), .BUS_WIDTH(BW), .DATA_WIDTH(DW)) bus ();

    apb_rr_arbiter #(
        .MASTER_PORTS (MP),
        .BUS_WIDTH    (BW),
        .DATA_WIDTH   (DW),
        .TIMEOUT      (8),
        .TIMEOUT_DATA (16'hDEAD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus.slave),
        .grant       (grant),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_master(input int i, input logic [BW-1:0] addr,
                                input logic wr, input logic [DW-1:0] wd);
        bus.S_PADDR[i*BW +: BW] = addr;
        bus.S_PWRITE[i]         = wr;
        bus.S_PWDATA[i*DW +: DW] = wd;
    endtask

    initial begin
        int exp_m;
        reset         = 1'b0;
        bus.S_PADDR   = '0;
        bus.S_PWRITE  = '0;
        bus.S_PSELx   = '0;
        bus.S_PENABLE = '0;
        bus.S_PWDATA  = '0;
        bus.M_PRDATA  = '0;
        bus.M_PREADY  = 1'b0;
        #1;
        check("rst_grant", 64'(grant), 64'h0);
        check("rst_psel", 64'(bus.M_PSEL), 64'h0);
        check("rst_penable", 64'(bus.M_PENABLE), 64'h0);
        check("rst_pready", 64'(bus.S_PREADY), 64'h0);
        check("rst_terr", 64'(timeout_err), 64'h0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;

        // Master 2 read of 0x0040, two wait states then 0x1234
        drive_master(2, 20'h00040, 1'b0, 16'h0);
        bus.S_PSELx = 4'b0100;
        #1;
        check("s1_idle_psel", 64'(bus.M_PSEL), 64'h0);
        step();
        check("s1_setup_psel", 64'(bus.M_PSEL), 64'h1);
        check("s1_setup_pen", 64'(bus.M_PENABLE), 64'h0);
        check("s1_grant", 64'(grant), 64'h4);
        check("s1_paddr", 64'(bus.M_PADDR), 64'h00040);
        step();
        check("s1_acc_pen", 64'(bus.M_PENABLE), 64'h1);
        check("s1_wait1_rdy", 64'(bus.S_PREADY), 64'h0);
        step();
        check("s1_wait2_rdy", 64'(bus.S_PREADY), 64'h0);
        step();
        bus.M_PRDATA = 16'h1234;
        bus.M_PREADY = 1'b1;
        #1;
        check("s1_pready", 64'(bus.S_PREADY), 64'h4);
        check("s1_prdata", 64'(bus.S_PRDATA), 64'h0000_1234_0000_0000);
        step();
        bus.S_PSELx  = '0;
        bus.M_PREADY = 1'b0;
        #1;
        check("s1_done_psel", 64'(bus.M_PSEL), 64'h0);
        check("s1_done_grant", 64'(grant), 64'h0);

        // All four masters request continuously from reset
        reset = 1'b0;
        step();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) drive_master(i, 20'hF0000 | 20'(i * 16), 1'b0, 16'h0);
        bus.S_PSELx  = 4'hF;
        bus.M_PREADY = 1'b1;
        bus.M_PRDATA = 16'h0BAD;
        #1;
        for (int k = 0; k < 5; k++) begin
            exp_m = k % 4;
            step();
            check("s2_grant", 64'(grant), 64'(1 << exp_m));
            check("s2_paddr", 64'(bus.M_PADDR), 64'(20'hF0000 | 20'(exp_m * 16)));
            step();
            check("s2_pready", 64'(bus.S_PREADY), 64'(1 << exp_m));
            step();
            check("s2_idle_grant", 64'(grant), 64'h0);
        end
        bus.S_PSELx  = '0;
        bus.M_PREADY = 1'b0;
        #1;

        // Master 1 write 0xBEEF, slave never ready -> timeout on 8th ACCESS cycle
        drive_master(1, 20'h00100, 1'b1, 16'hBEEF);
        bus.S_PSELx = 4'b0010;
        #1;
        step();
        check("s3_grant", 64'(grant), 64'h2);
        check("s3_pwrite", 64'(bus.M_PWRITE), 64'h1);
        check("s3_pwdata", 64'(bus.M_PWDATA), 64'hBEEF);
        step();
        for (int j = 0; j < 7; j++) begin
            check("s3_wait_rdy", 64'(bus.S_PREADY), 64'h0);
            check("s3_wait_err", 64'(timeout_err), 64'h0);
            step();
        end
        check("s3_tmo_rdy", 64'(bus.S_PREADY), 64'h2);
        check("s3_tmo_data", 64'(bus.S_PRDATA), 64'h0000_0000_DEAD_0000);
        check("s3_tmo_err", 64'(timeout_err), 64'h1);
        step();
        bus.S_PSELx = '0;
        #1;
        check("s3_idle_psel", 64'(bus.M_PSEL), 64'h0);
        check("s3_idle_err", 64'(timeout_err), 64'h0);
        check("s3_idle_grant", 64'(grant), 64'h0);

        // Master 3 aborts in ACCESS; masters 0 and 2 then compete
        drive_master(3, 20'h00300, 1'b0, 16'h0);
        bus.S_PSELx = 4'b1000;
        #1;
        step();
        check("s4_grant", 64'(grant), 64'h8);
        step();
        check("s4_pen", 64'(bus.M_PENABLE), 64'h1);
        bus.S_PSELx  = 4'b0101;
        bus.M_PREADY = 1'b1;
        #1;
        check("s4_abort_rdy", 64'(bus.S_PREADY), 64'h0);
        step();
        check("s4_abort_psel", 64'(bus.M_PSEL), 64'h0);
        check("s4_abort_grant", 64'(grant), 64'h0);
        step();
        check("s4_next_grant", 64'(grant), 64'h1);
        step();
        check("s4_m0_rdy", 64'(bus.S_PREADY), 64'h1);
        step();
        bus.S_PSELx  = '0;
        bus.M_PREADY = 1'b0;
        #1;

        // Reset during ACCESS of master 2, then masters 1 and 2 request
        drive_master(2, 20'h00200, 1'b0, 16'h0);
        bus.S_PSELx = 4'b0100;
        #1;
        step();
        check("s5_grant", 64'(grant), 64'h4);
        step();
        check("s5_pen", 64'(bus.M_PENABLE), 64'h1);
        bus.M_PREADY = 1'b1;
        reset        = 1'b0;
        #1;
        check("s5_rst_psel", 64'(bus.M_PSEL), 64'h0);
        check("s5_rst_pen", 64'(bus.M_PENABLE), 64'h0);
        check("s5_rst_grant", 64'(grant), 64'h0);
        check("s5_rst_rdy", 64'(bus.S_PREADY), 64'h0);
        step();
        reset       = 1'b1;
        bus.S_PSELx = 4'b0110;
        #1;
        check("s5_idle_grant", 64'(grant), 64'h0);
        step();
        check("s5_first_grant", 64'(grant), 64'h2);
        step();
        check("s5_first_rdy", 64'(bus.S_PREADY), 64'h2);
        step();
        check("s5_gap_grant", 64'(grant), 64'h0);
        step();
        check("s5_second_grant", 64'(grant), 64'h4);
        step();
        check("s5_second_rdy", 64'(bus.S_PREADY), 64'h4);
        step();
        bus.S_PSELx  = '0;
        bus.M_PREADY = 1'b0;
        #1;

        // Ready lands exactly on the timeout cycle: real data wins
        drive_master(1, 20'h00104, 1'b0, 16'h0);
        bus.S_PSELx = 4'b0010;
        #1;
        step();
        check("s6_grant", 64'(grant), 64'h2);
        step();
        for (int j = 0; j < 7; j++) begin
            check("s6_wait_rdy", 64'(bus.S_PREADY), 64'h0);
            step();
        end
        bus.M_PREADY = 1'b1;
        bus.M_PRDATA = 16'h5A5A;
        #1;
        check("s6_rdy", 64'(bus.S_PREADY), 64'h2);
        check("s6_data", 64'(bus.S_PRDATA), 64'h0000_0000_5A5A_0000);
        check("s6_no_err", 64'(timeout_err), 64'h0);
        step();
        bus.S_PSELx  = '0;
        bus.M_PREADY = 1'b0;
        #1;
        check("s6_idle_grant", 64'(grant), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
